sfp_ctrl: RTL and testbench



---
 rtl/sfp_ctrl.sv | 119 +++++++++++
 tb/tb_sfp_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_ctrl.sv
// Row sequencer for the SFP accumulate/ReLU path: pops OFIFO rows, optionally
// reads the matching PSUM row, combines per lane and writes back in place.
module sfp_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw:0]         num_rows,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic                     accum,
    input  logic                     relu,
    input  logic                     passthrough,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [addr_bw-1:0]       sram_a,
    output logic [col*psum_bw-1:0]   sram_d,
    input  logic [col*psum_bw-1:0]   sram_q,
    output logic                     busy,
    output logic                     done
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | waiting for / popping an OFIFO row, SRAM read when accumulating
    // WRITE | writing the combined row back to the same address
    // DONE  | one-cycle end-of-pass pulse
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [addr_bw:0]   cnt_one  = 1;
    localparam logic [addr_bw-1:0] addr_one = 1;

    state_t                 state;
    logic [addr_bw-1:0]     addr;
    logic [addr_bw:0]       cnt;
    logic [addr_bw:0]       rows;
    logic                   accum_q;
    logic                   relu_q;
    logic                   pass_q;
    logic [col*psum_bw-1:0] row_q;
    logic [col*psum_bw-1:0] result;
    logic [psum_bw-1:0]     o_lane;
    logic [psum_bw-1:0]     p_lane;
    logic [psum_bw-1:0]     sum_lane;
    logic                   rd_access;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            addr    <= '0;
            cnt     <= '0;
            rows    <= '0;
            accum_q <= 1'b0;
            relu_q  <= 1'b0;
            pass_q  <= 1'b0;
            row_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr    <= base_addr;
                        rows    <= num_rows;
                        cnt     <= '0;
                        accum_q <= accum;
                        relu_q  <= relu;
                        pass_q  <= passthrough;
                        state   <= (num_rows == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (ofifo_valid) begin
                        row_q <= ofifo_out;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    cnt   <= cnt + cnt_one;
                    addr  <= addr + addr_one;
                    state <= (cnt == rows - cnt_one) ? DONE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane arithmetic wraps at psum_bw bits; the MSB of the wrapped sum drives ReLU.
    always_comb begin
        result   = '0;
        o_lane   = '0;
        p_lane   = '0;
        sum_lane = '0;
        for (int i = 0; i < col; i++) begin
            o_lane   = row_q[i*psum_bw +: psum_bw];
            p_lane   = sram_q[i*psum_bw +: psum_bw];
            sum_lane = accum_q ? (p_lane + o_lane) : o_lane;
            if (pass_q)
                result[i*psum_bw +: psum_bw] = o_lane;
            else if (relu_q && sum_lane[psum_bw-1])
                result[i*psum_bw +: psum_bw] = '0;
            else
                result[i*psum_bw +: psum_bw] = sum_lane;
        end
    end

    assign ofifo_rd  = (state == READ) && ofifo_valid;
    assign rd_access = ofifo_rd && accum_q && !pass_q;
    assign sram_cen  = !(rd_access || (state == WRITE));
    assign sram_wen  = (state != WRITE);
    assign sram_a    = addr;
    assign sram_d    = (state == WRITE) ? result : '0;
    assign busy      = (state == READ) || (state == WRITE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_sfp_ctrl.sv
// Bench for sfp_ctrl: behavioural SRAM/OFIFO environment plus a row-level
// reference that predicts every write address and data word of a pass.
module tb_sfp_ctrl;

    localparam int COL = 8;
    localparam int PB  = 16;
    localparam int AB  = 4;
    localparam int W   = COL * PB;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AB:0]   num_rows;
    logic [AB-1:0] base_addr;
    logic          accum;
    logic          relu;
    logic          passthrough;
    logic          ofifo_valid;
    logic [W-1:0]  ofifo_out;
    logic          ofifo_rd;
    logic          sram_cen;
    logic          sram_wen;
    logic [AB-1:0] sram_a;
    logic [W-1:0]  sram_d;
    logic [W-1:0]  sram_q;
    logic          busy;
    logic          done;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] mem [16];
    logic [W-1:0] fifo_q [$];

    always #5 clk = ~clk;

    sfp_ctrl #(.col(COL), .psum_bw(PB), .addr_bw(AB)) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .base_addr(base_addr), .accum(accum), .relu(relu),
        .passthrough(passthrough), .ofifo_valid(ofifo_valid),
        .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd), .sram_cen(sram_cen),
        .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d),
        .sram_q(sram_q), .busy(busy), .done(done)
    );

    function automatic logic [W-1:0] rand_row();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Per-lane signed arithmetic, wrapped to 16 bits.
    function automatic logic [W-1:0] sfp_row(input logic [W-1:0] o_row, input logic [W-1:0] p_row,
                                             input bit acc, input bit rl, input bit pt);
        logic [W-1:0]       r;
        int                 o;
        int                 p;
        int                 s;
        logic signed [15:0] w;
        r = '0;
        for (int i = 0; i < COL; i++) begin
            o = int'($signed(o_row[i*PB +: PB]));
            p = int'($signed(p_row[i*PB +: PB]));
            s = acc ? o + p : o;
            w = s[15:0];
            if (pt)
                r[i*PB +: PB] = o_row[i*PB +: PB];
            else if (rl && w < 0)
                r[i*PB +: PB] = 16'd0;
            else
                r[i*PB +: PB] = w;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill(input int n);
        fifo_q.delete();
        for (int k = 0; k < n; k++) fifo_q.push_back(rand_row());
    endtask

    task automatic run_pass(input int base, input int n, input bit acc, input bit rl, input bit pt,
                            input int vpct, input int hold, input int abort_wr);
        logic [W-1:0]  em [16];
        logic [AB-1:0] ea [$];
        logic [W-1:0]  ed [$];
        logic [AB-1:0] a;
        int            idx, writes, reads, pops;
        bit            done_seen, prev_rd, prev_wr, prev_rda, rda, wr;
        logic [AB-1:0] prev_a;
        logic [W-1:0]  prev_d;

        em = mem;
        for (int k = 0; k < n; k++) begin
            a = AB'(base + k);
            ed.push_back(sfp_row(fifo_q[k], em[a], acc, rl, pt));
            ea.push_back(a);
            em[a] = ed[k];
        end
        idx = 0; writes = 0; reads = 0; pops = 0;
        done_seen = 0; prev_rd = 0; prev_wr = 0; prev_rda = 0;
        prev_a = '0; prev_d = '0;

        @(negedge clk);
        start = 1'b1; num_rows = (AB+1)'(n); base_addr = AB'(base);
        accum = acc; relu = rl; passthrough = pt;
        ofifo_valid = 1'b0; ofifo_out = rand_row(); sram_q = rand_row();
        #1 chk("idle_before_start", {busy, done, ofifo_rd, sram_cen}, 4'b0001);

        for (int c = 1; c <= 600 && !done_seen; c++) begin
            @(negedge clk);
            if (prev_rd) idx++;
            if (prev_wr) mem[prev_a] = prev_d;
            sram_q      = prev_rda ? mem[prev_a] : rand_row();
            start       = ($urandom_range(7) == 0);
            accum       = 1'($urandom_range(1));
            relu        = 1'($urandom_range(1));
            passthrough = 1'($urandom_range(1));
            num_rows    = (AB+1)'($urandom_range(31));
            base_addr   = AB'($urandom_range(15));
            ofifo_valid = (idx < n) && (c > hold) && (int'($urandom_range(99)) < vpct);
            ofifo_out   = ofifo_valid ? fifo_q[idx] : rand_row();
            #1;
            rda = !sram_cen && sram_wen;
            wr  = !sram_cen && !sram_wen;
            chk("rd_without_valid", ofifo_rd && !ofifo_valid, 0);
            chk("busy_vs_done", busy, !done);
            if (ofifo_rd) begin
                chk("rd_access", rda, acc && !pt);
                if (rda) chk("rd_addr", sram_a, ea[pops]);
                pops++;
            end else begin
                chk("no_rd_access", rda, 0);
            end
            if (rda) reads++;
            if (wr) begin
                if (writes < n) begin
                    chk("wr_addr", sram_a, ea[writes]);
                    chk("wr_data", sram_d, ed[writes]);
                end else begin
                    chk("extra_write", wr, 0);
                end
                writes++;
            end
            if (vpct == 100) chk("done_timing", done, c == 2*n + 1 + hold);
            if (abort_wr >= 0 && wr && writes == abort_wr + 1) begin
                reset = 1'b0;
                #1 chk("reset_outputs", {ofifo_rd, sram_cen, sram_wen, sram_a, sram_d, busy, done},
                       {1'b0, 1'b1, 1'b1, 4'd0, 128'd0, 1'b0, 1'b0});
                start = 1'b0;
                @(negedge clk);
                reset = 1'b1; ofifo_valid = 1'b1; ofifo_out = rand_row();
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    #1 chk("post_reset_quiet", {ofifo_rd, sram_cen, busy, done}, 4'b0100);
                end
                ofifo_valid = 1'b0;
                return;
            end
            if (done) done_seen = 1;
            prev_rd = ofifo_rd; prev_wr = wr; prev_rda = rda; prev_a = sram_a; prev_d = sram_d;
        end
        start = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("write_count", writes, n);
        chk("pop_count", pops, n);
        chk("read_count", reads, (acc && !pt) ? n : 0);
        for (int i = 0; i < 16; i++) chk("sram_image", mem[i], em[i]);
        @(negedge clk);
        ofifo_valid = 1'b1;
        #1 chk("idle_after_done", {busy, done, ofifo_rd, sram_cen}, 4'b0001);
        ofifo_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] tmp;
        reset = 1'b0; start = 1'b0; num_rows = '0; base_addr = '0;
        accum = 1'b0; relu = 1'b0; passthrough = 1'b0;
        ofifo_valid = 1'b0; ofifo_out = '0; sram_q = '0;
        for (int i = 0; i < 16; i++) mem[i] = rand_row();
        #1 chk("reset_values", {ofifo_rd, sram_cen, sram_wen, sram_a, sram_d, busy, done},
               {1'b0, 1'b1, 1'b1, 4'd0, 128'd0, 1'b0, 1'b0});
        #20;
        @(negedge clk) reset = 1'b1;

        // Accumulate: 5 + (-7) = -2 at base 3
        tmp = rand_row(); tmp[15:0] = 16'd5; mem[3] = tmp;
        fill(2); tmp = fifo_q[0]; tmp[15:0] = 16'hFFF9; fifo_q[0] = tmp;
        run_pass(3, 2, 1, 0, 0, 100, 0, -1);
        chk("accum_lane0", mem[3][15:0], 16'hFFFE);

        // Same stimulus with ReLU
        tmp = rand_row(); tmp[15:0] = 16'd5; mem[3] = tmp;
        fill(2); tmp = fifo_q[0]; tmp[15:0] = 16'hFFF9; fifo_q[0] = tmp;
        run_pass(3, 2, 1, 1, 0, 100, 0, -1);
        chk("relu_lane0", mem[3][15:0], 16'h0000);

        // Passthrough overrides accum and relu
        fill(1); tmp = fifo_q[0]; tmp[15:0] = 16'h8001; fifo_q[0] = tmp;
        run_pass(6, 1, 1, 1, 1, 100, 0, -1);
        chk("pass_lane0", mem[6][15:0], 16'h8001);

        // OFIFO empty for three READ cycles
        fill(2);
        run_pass(9, 2, 1, 0, 0, 100, 3, -1);

        // Address wrap from 15 to 0
        fill(2);
        run_pass(15, 2, 1, 1, 0, 100, 0, -1);

        // Empty pass
        fill(0);
        run_pass(5, 0, 1, 0, 0, 100, 0, -1);

        // Reset during the second WRITE
        fill(3);
        run_pass(2, 3, 1, 0, 0, 100, 0, 1);

        // Randomized passes, including wrapping passes longer than the SRAM
        for (int t = 0; t < 12; t++) begin
            int n;
            n = int'($urandom_range(20, 1));
            fill(n);
            run_pass(int'($urandom_range(15)), n, 1'($urandom_range(1)), 1'($urandom_range(1)),
                     ($urandom_range(3) == 0), (t < 4) ? 100 : int'($urandom_range(100, 50)), 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
